// File: rtl/flash_boot_copy.sv
// flash_boot_copy
// ---------------------------------------------------------------------------
// Copies WORDS 32-bit words from flash (starting at word address SRC_BASE) to
// RAM (starting at word address DST_BASE) over a Wishbone master port. The
// copy is done in chunks of up to CHUNK = 2**BUF_ADDR_BITS words. Each chunk
// is read as an incrementing burst into a local buffer, followed by one idle
// cycle, then written back as an incrementing burst, followed by one idle
// cycle.
//
// Optional feature: define FLASH_BOOT_CSUM_EN to build an additive checksum
// of every word read (csum). Without it csum is tied to zero and no
// accumulator exists.
//
// Ports
//   clk, rst        single clock, synchronous active-high reset
//   start           one-cycle copy request (ignored while busy)
//   busy            copy in progress
//   done            last copy finished; cleared by the next accepted start
//   csum            additive checksum of the words read (or 0)
//   wbm_*           Wishbone master: cyc/stb/we, word address [31:2],
//                   cti (010 incrementing, 111 end of burst), bte=00,
//                   sel=1111, write data out, read data/ack in
// ---------------------------------------------------------------------------
module flash_boot_copy #(
  parameter logic [29:0] SRC_BASE      = 30'h3F80_0000,
  parameter logic [29:0] DST_BASE      = 30'h0000_0000,
  parameter int unsigned WORDS         = 4096,
  parameter int unsigned BUF_ADDR_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] csum,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [31:2] wbm_addr_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_data_o,
  input  logic [31:0] wbm_data_i,
  input  logic        wbm_ack_i
);

  localparam int unsigned CHUNK = 1 << BUF_ADDR_BITS;
  localparam logic [24:0] CHUNK_W = 25'(CHUNK);
  localparam logic [24:0] WORDS_W = 25'(WORDS);
  localparam logic [BUF_ADDR_BITS:0] CHUNK_LEN = (BUF_ADDR_BITS + 1)'(CHUNK);
  localparam logic [BUF_ADDR_BITS:0] LEN_ONE = (BUF_ADDR_BITS + 1)'(1);
  localparam logic [BUF_ADDR_BITS-1:0] BEAT_ONE = BUF_ADDR_BITS'(1);
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_END = 3'b111;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    GAP_R = 3'd2,
    WR    = 3'd3,
    GAP_W = 3'd4,
    FIN   = 3'd5
  } state_t;

  state_t                   state;
  logic [24:0]              remaining;
  logic [24:0]              offset;
  logic [BUF_ADDR_BITS-1:0] beat;
  logic [BUF_ADDR_BITS:0]   len;
  logic [31:0]              buf_mem [CHUNK];

  logic                     accept;
  logic                     beat_ack;
  logic                     last_beat;
  logic                     next_last;
  logic [BUF_ADDR_BITS-1:0] beat_nxt;

  // Length of the next chunk: the smaller of CHUNK and the words still to go.
  function automatic logic [BUF_ADDR_BITS:0] chunk_len(input logic [24:0] rem);
    if (rem >= CHUNK_W) begin
      chunk_len = CHUNK_LEN;
    end else begin
      chunk_len = rem[BUF_ADDR_BITS:0];
    end
  endfunction

  // Cycle type of the first beat of a burst of length n.
  function automatic logic [2:0] first_cti(input logic [BUF_ADDR_BITS:0] n);
    first_cti = (n == LEN_ONE) ? CTI_END : CTI_INCR;
  endfunction

  assign wbm_bte_o = 2'b00;
  assign wbm_sel_o = 4'b1111;

  // A start is taken in IDLE, or in FIN once the one-cycle busy of an empty
  // copy has dropped; everywhere else it is ignored.
  assign accept    = start & ((state == IDLE) | ((state == FIN) & ~busy));
  // Acks are only meaningful while a strobe is outstanding.
  assign beat_ack  = wbm_stb_o & wbm_ack_i;
  assign beat_nxt  = beat + BEAT_ONE;
  assign last_beat = ({1'b0, beat} == (len - LEN_ONE));
  assign next_last = ({1'b0, beat_nxt} == (len - LEN_ONE));

  // Capture each acknowledged read word into the chunk buffer.
  always_ff @(posedge clk) begin
    if ((state == RD) && beat_ack) begin
      buf_mem[beat] <= wbm_data_i;
    end
  end

  // Copy sequencer: all bus outputs and status flags are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      wbm_cyc_o  <= 1'b0;
      wbm_stb_o  <= 1'b0;
      wbm_we_o   <= 1'b0;
      wbm_cti_o  <= CTI_CLASSIC;
      wbm_addr_o <= 30'h0;
      wbm_data_o <= 32'h0;
      remaining  <= 25'h0;
      offset     <= 25'h0;
      beat       <= '0;
      len        <= '0;
    end else if (accept) begin
      busy      <= 1'b1;
      done      <= 1'b0;
      remaining <= WORDS_W;
      offset    <= 25'h0;
      beat      <= '0;
      if (WORDS_W == 25'h0) begin
        // Nothing to copy: spend a single busy cycle in FIN, no bus cycle.
        state <= FIN;
      end else begin
        state      <= RD;
        len        <= chunk_len(WORDS_W);
        wbm_cyc_o  <= 1'b1;
        wbm_stb_o  <= 1'b1;
        wbm_we_o   <= 1'b0;
        wbm_addr_o <= SRC_BASE;
        wbm_cti_o  <= first_cti(chunk_len(WORDS_W));
      end
    end else begin
      case (state)
        IDLE: begin
          state <= IDLE;
        end
        RD: begin
          if (beat_ack) begin
            if (last_beat) begin
              wbm_cyc_o <= 1'b0;
              wbm_stb_o <= 1'b0;
              wbm_cti_o <= CTI_CLASSIC;
              beat      <= '0;
              state     <= GAP_R;
            end else begin
              beat       <= beat_nxt;
              wbm_addr_o <= wbm_addr_o + 30'h1;
              wbm_cti_o  <= next_last ? CTI_END : CTI_INCR;
            end
          end
        end
        GAP_R: begin
          // Buffer entry 0 was written at least one edge ago, so it can be
          // presented together with the first write strobe.
          state      <= WR;
          wbm_cyc_o  <= 1'b1;
          wbm_stb_o  <= 1'b1;
          wbm_we_o   <= 1'b1;
          wbm_addr_o <= DST_BASE + {5'h0, offset};
          wbm_cti_o  <= first_cti(len);
          wbm_data_o <= buf_mem[0];
        end
        WR: begin
          if (beat_ack) begin
            if (last_beat) begin
              wbm_cyc_o <= 1'b0;
              wbm_stb_o <= 1'b0;
              wbm_we_o  <= 1'b0;
              wbm_cti_o <= CTI_CLASSIC;
              beat      <= '0;
              remaining <= remaining - 25'(len);
              offset    <= offset + 25'(len);
              state     <= GAP_W;
            end else begin
              beat       <= beat_nxt;
              wbm_addr_o <= wbm_addr_o + 30'h1;
              wbm_cti_o  <= next_last ? CTI_END : CTI_INCR;
              wbm_data_o <= buf_mem[beat_nxt];
            end
          end
        end
        GAP_W: begin
          if (remaining != 25'h0) begin
            state      <= RD;
            len        <= chunk_len(remaining);
            wbm_cyc_o  <= 1'b1;
            wbm_stb_o  <= 1'b1;
            wbm_we_o   <= 1'b0;
            wbm_addr_o <= SRC_BASE + {5'h0, offset};
            wbm_cti_o  <= first_cti(chunk_len(remaining));
          end else begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        FIN: begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          wbm_cyc_o <= 1'b0;
          wbm_stb_o <= 1'b0;
          wbm_we_o  <= 1'b0;
          wbm_cti_o <= CTI_CLASSIC;
        end
      endcase
    end
  end

`ifdef FLASH_BOOT_CSUM_EN
  logic [31:0] csum_acc;

  // Running sum of every acknowledged read word, cleared when a copy starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum_acc <= 32'h0;
    end else if (accept) begin
      csum_acc <= 32'h0;
    end else if ((state == RD) && beat_ack) begin
      csum_acc <= csum_acc + wbm_data_i;
    end
  end

  assign csum = csum_acc;
`else
  assign csum = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_flash_boot_copy.sv
// Bench for flash_boot_copy: three instances (multi-chunk copy, empty copy,
// address-wrapping copy with a single-word tail chunk) share one bus model
// that acts as flash/RAM slave and checks every beat against a queue of
// expected beats built from a reference model when each copy is started.
module tb_flash_boot_copy;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start [N];
  logic        busy  [N];
  logic        done  [N];
  logic [31:0] csum  [N];
  logic        cyc   [N];
  logic        stb   [N];
  logic [31:2] addr  [N];
  logic [2:0]  cti   [N];
  logic [1:0]  bte   [N];
  logic [3:0]  sel   [N];
  logic        we    [N];
  logic [31:0] dout  [N];
  logic [31:0] din   [N] = '{32'h0, 32'h0, 32'h0};
  logic        ack   [N] = '{1'b0, 1'b0, 1'b0};

  flash_boot_copy #(.SRC_BASE(30'h100), .DST_BASE(30'h200), .WORDS(20), .BUF_ADDR_BITS(4)) u_a (
    .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]), .csum(csum[0]),
    .wbm_cyc_o(cyc[0]), .wbm_stb_o(stb[0]), .wbm_addr_o(addr[0]), .wbm_cti_o(cti[0]),
    .wbm_bte_o(bte[0]), .wbm_sel_o(sel[0]), .wbm_we_o(we[0]), .wbm_data_o(dout[0]),
    .wbm_data_i(din[0]), .wbm_ack_i(ack[0]));

  flash_boot_copy #(.SRC_BASE(30'h100), .DST_BASE(30'h200), .WORDS(0), .BUF_ADDR_BITS(4)) u_b (
    .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]), .csum(csum[1]),
    .wbm_cyc_o(cyc[1]), .wbm_stb_o(stb[1]), .wbm_addr_o(addr[1]), .wbm_cti_o(cti[1]),
    .wbm_bte_o(bte[1]), .wbm_sel_o(sel[1]), .wbm_we_o(we[1]), .wbm_data_o(dout[1]),
    .wbm_data_i(din[1]), .wbm_ack_i(ack[1]));

  flash_boot_copy #(.SRC_BASE(30'h3FFF_FFF8), .DST_BASE(30'h3FFF_FFFC), .WORDS(17), .BUF_ADDR_BITS(4)) u_c (
    .clk(clk), .rst(rst), .start(start[2]), .busy(busy[2]), .done(done[2]), .csum(csum[2]),
    .wbm_cyc_o(cyc[2]), .wbm_stb_o(stb[2]), .wbm_addr_o(addr[2]), .wbm_cti_o(cti[2]),
    .wbm_bte_o(bte[2]), .wbm_sel_o(sel[2]), .wbm_we_o(we[2]), .wbm_data_o(dout[2]),
    .wbm_data_i(din[2]), .wbm_ack_i(ack[2]));

  function automatic logic [29:0] src_of(input int i);
    case (i)
      0, 1:    return 30'h100;
      default: return 30'h3FFF_FFF8;
    endcase
  endfunction

  function automatic logic [29:0] dst_of(input int i);
    case (i)
      0, 1:    return 30'h200;
      default: return 30'h3FFF_FFFC;
    endcase
  endfunction

  function automatic int words_of(input int i);
    case (i)
      0:       return 20;
      1:       return 0;
      default: return 17;
    endcase
  endfunction

  function automatic logic [31:0] flash_word(input logic [29:0] a);
    return ({2'b00, a} * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  typedef struct {
    int          inst;
    logic        we;
    logic [29:0] addr;
    logic [2:0]  cti;
    logic [31:0] data;
  } beat_t;

  typedef struct {
    int inst;
    int waits;
    bit spur;
    int rst_beat;
    bit mid_start;
    int exp_busy;
  } run_t;

  beat_t       exp_q [$];
  logic [31:0] ram [logic [29:0]];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          waits = 0;
  bit          spur = 1'b0;
  int          beats_seen = 0;
  int          wcnt [N] = '{0, 0, 0};
  int          busy_cyc [N] = '{0, 0, 0};
  int          gap [N] = '{0, 0, 0};
  logic        done_prev [N] = '{1'b0, 1'b0, 1'b0};

  task automatic check(input bit ok, input string name, input logic [95:0] act, input logic [95:0] req);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference model: push the expected beat sequence of one copy, return its sum.
  function automatic logic [31:0] build_model(input int i);
    logic [24:0] rem;
    logic [29:0] off;
    logic [31:0] sum;
    int          len;
    rem = 25'(words_of(i));
    off = 30'h0;
    sum = 32'h0;
    while (rem != 25'h0) begin
      len = (rem > 25'd16) ? 16 : int'(rem);
      for (int k = 0; k < len; k++) begin
        exp_q.push_back('{i, 1'b0, src_of(i) + off + 30'(k), (k == len - 1) ? 3'b111 : 3'b010, 32'h0});
        sum = sum + flash_word(src_of(i) + off + 30'(k));
      end
      for (int k = 0; k < len; k++) begin
        exp_q.push_back('{i, 1'b1, dst_of(i) + off + 30'(k), (k == len - 1) ? 3'b111 : 3'b010,
                          flash_word(src_of(i) + off + 30'(k))});
      end
      rem = rem - 25'(len);
      off = off + 30'(len);
    end
    return sum;
  endfunction

  // Bus slave and monitor: compares each strobed cycle with the head of the
  // expected queue, acks after `waits` wait cycles, and tracks idle gaps.
  always @(negedge clk) begin
    beat_t e;
    for (int i = 0; i < N; i++) begin
      ack[i] = 1'b0;
      if (rst) begin
        wcnt[i] = 0;
      end else begin
        if (cyc[i] && stb[i]) begin
          if (exp_q.size() == 0) begin
            check(1'b0, "extra_beat", {4'(i), addr[i]}, 96'h0);
            ack[i] = 1'b1;
          end else begin
            e = exp_q[0];
            check({sel[i], bte[i], 4'(i), we[i], addr[i], cti[i], (we[i] ? dout[i] : 32'h0)} ==
                  {4'hF, 2'b00, 4'(e.inst), e.we, e.addr, e.cti, (e.we ? e.data : 32'h0)},
                  "beat",
                  {sel[i], bte[i], 4'(i), we[i], addr[i], cti[i], (we[i] ? dout[i] : 32'h0)},
                  {4'hF, 2'b00, 4'(e.inst), e.we, e.addr, e.cti, (e.we ? e.data : 32'h0)});
            if (wcnt[i] >= waits) begin
              ack[i] = 1'b1;
              din[i] = flash_word(addr[i]);
              if (we[i]) ram[addr[i]] = dout[i];
              void'(exp_q.pop_front());
              wcnt[i] = 0;
              beats_seen++;
            end else begin
              wcnt[i]++;
              din[i] = $urandom;
            end
          end
        end else if (spur && !stb[i]) begin
          ack[i] = 1'($urandom_range(0, 1));
          din[i] = $urandom;
        end
        if (busy[i]) busy_cyc[i]++;
        if (busy[i] && !cyc[i]) begin
          gap[i]++;
        end else if (cyc[i]) begin
          if (gap[i] != 0) check(gap[i] == 1, "gap_len", 96'(gap[i]), 96'd1);
          gap[i] = 0;
        end
        if (done[i] && !done_prev[i]) begin
          check(gap[i] == 1, "final_gap", 96'(gap[i]), 96'd1);
          gap[i] = 0;
        end
      end
      done_prev[i] = done[i];
    end
  end

  task automatic do_run(input run_t r);
    int          i;
    int          base;
    int          bad;
    logic [31:0] sum;
    logic [31:0] exp_csum;
    i = r.inst;
    waits = r.waits;
    spur = r.spur;
    exp_q.delete();
    sum = build_model(i);
    ram.delete();
    busy_cyc[i] = 0;
    gap[i] = 0;
    base = beats_seen;
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
    check(busy[i] == 1'b1 && done[i] == 1'b0, "launch", {busy[i], done[i]}, 2'b10);
    if (r.rst_beat >= 0) begin
      for (int c = 0; c < 2000 && (beats_seen - base) < r.rst_beat; c++) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check({cyc[i], stb[i], busy[i], done[i]} == 4'b0000, "rst_mid", {cyc[i], stb[i], busy[i], done[i]}, 4'b0000);
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check({cyc[i], busy[i], done[i]} == 3'b000, "rst_after", {cyc[i], busy[i], done[i]}, 3'b000);
      return;
    end
    for (int c = 0; c < 4000 && !done[i]; c++) begin
      start[i] = (r.mid_start && c == 8) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    start[i] = 1'b0;
    check(done[i] == 1'b1, "done_timeout", done[i], 1'b1);
    check(exp_q.size() == 0, "leftover_beats", exp_q.size(), 0);
    check(busy_cyc[i] == r.exp_busy, "busy_cycles", busy_cyc[i], r.exp_busy);
    bad = 0;
    for (int k = 0; k < words_of(i); k++) begin
      if (!ram.exists(dst_of(i) + 30'(k)) || ram[dst_of(i) + 30'(k)] != flash_word(src_of(i) + 30'(k))) bad++;
    end
    check(bad == 0 && ram.size() == words_of(i), "ram_image", {32'(bad), 32'(ram.size())}, {32'd0, 32'(words_of(i))});
`ifdef FLASH_BOOT_CSUM_EN
    exp_csum = sum;
`else
    exp_csum = 32'h0;
`endif
    check(csum[i] == exp_csum, "csum", csum[i], exp_csum);
    repeat (2) @(negedge clk);
    check(done[i] == 1'b1 && busy[i] == 1'b0, "fin_hold", {busy[i], done[i]}, 2'b01);
  endtask

  run_t runs [7];

  initial begin
    runs[0] = '{0, 0, 1'b0, -1, 1'b0, 44};
    runs[1] = '{0, 2, 1'b1, -1, 1'b0, 124};
    runs[2] = '{0, 0, 1'b0, 5, 1'b0, 0};
    runs[3] = '{0, 1, 1'b0, -1, 1'b1, 84};
    runs[4] = '{1, 0, 1'b1, -1, 1'b0, 1};
    runs[5] = '{2, 0, 1'b1, -1, 1'b0, 38};
    runs[6] = '{2, 1, 1'b0, -1, 1'b0, 72};
    for (int i = 0; i < N; i++) start[i] = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    for (int i = 0; i < N; i++) begin
      check({busy[i], done[i], cyc[i], stb[i], we[i], cti[i], addr[i], dout[i], csum[i]} == 98'h0,
            "reset_state", {busy[i], done[i], cyc[i], stb[i], we[i], cti[i], addr[i], dout[i]}, 96'h0);
    end
    rst = 1'b0;
    @(negedge clk);
    check({busy[0], cyc[0]} == 2'b00, "rst_over_start", {busy[0], cyc[0]}, 2'b00);
    for (int r = 0; r < 7; r++) do_run(runs[r]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end
endmodule

// File: doc/flash_boot_copy.md
FLASH_BOOT_COPY -- requirements
Module: flash_boot_copy

Interface
REQ-001 Parameter SRC_BASE, default 30'h3F80_0000, word address of the first flash word read.
REQ-002 Parameter DST_BASE, default 30'h0000_0000, word address of the first RAM word written.
REQ-003 Parameter WORDS, default 4096, number of 32-bit words copied, range 0..2^24.
REQ-004 Parameter BUF_ADDR_BITS, default 4, giving a chunk size CHUNK = 2^BUF_ADDR_BITS words.
REQ-005 Port clk, input, 1 bit: the single clock; the bus side also runs on it.
REQ-006 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 Port start, input, 1 bit: a one-cycle request to begin a copy.
REQ-008 Port busy, output, 1 bit: high while a copy is in progress.
REQ-009 Port done, output, 1 bit: high from copy completion until the next accepted start.
REQ-010 Port csum, output, 32 bits: additive checksum of the copied words (see Configuration).
REQ-011 Port wbm_cyc_o / wbm_stb_o, outputs, 1 bit each: Wishbone master cycle and strobe.
REQ-012 Port wbm_addr_o, output, [31:2]: word address.
REQ-013 Port wbm_cti_o, output, 3 bits: cycle type; wbm_bte_o, output, 2 bits, fixed at 2'b00.
REQ-014 Port wbm_sel_o, output, 4 bits, fixed at 4'b1111; wbm_we_o, output, 1 bit: write enable.
REQ-015 Port wbm_data_o, output, 32 bits: write data; wbm_data_i, input, 32 bits: read data; wbm_ack_i, input, 1 bit: acknowledge.

Function
REQ-016 The block SHALL implement the states IDLE, RD, GAP_R, WR, GAP_W and FIN.
REQ-017 In IDLE, start=1 SHALL take the block to RD on the next edge, clear done and csum, set busy, and load the remaining count with WORDS.
REQ-018 start SHALL be ignored while busy=1; it SHALL be accepted in FIN, where it restarts the copy.
REQ-019 With WORDS=0, an accepted start SHALL go directly to FIN, with busy high for exactly one cycle and no bus cycle issued.
REQ-020 Chunk length SHALL be L = min(CHUNK, remaining) words.
REQ-021 In RD the block SHALL hold cyc=stb=1 and we=0, starting at SRC_BASE + offset.
REQ-022 On each ack in RD, the block SHALL write wbm_data_i into buffer entry k and advance the address by 1 on the next edge.
REQ-023 On every beat, cti SHALL be 3'b010 for beats 0..L-2 and 3'b111 for beat L-1; a single-word chunk SHALL use 3'b111 only.
REQ-024 After the L-th ack in RD, cyc and stb SHALL deassert for exactly one cycle (GAP_R) before WR.
REQ-025 WR SHALL mirror RD with we=1, address DST_BASE + offset, and wbm_data_o = buffer[k].
REQ-026 In WR, wbm_data_o SHALL change only after an ack.
REQ-027 After the L-th ack in WR, the block SHALL pass through GAP_W (one idle cycle), subtract L from remaining and add L to offset.
REQ-028 From GAP_W, the block SHALL go to RD if remaining>0, otherwise to FIN.
REQ-029 FIN SHALL set busy=0 and done=1, and the block SHALL remain in FIN until start.
REQ-030 Wait states (stb=1, ack=0) SHALL hold address, cti, data and the beat index unchanged for any number of cycles.
REQ-031 An ack sampled while stb=0 SHALL be ignored.
REQ-032 Address arithmetic SHALL be 30-bit modulo 2^30; wrap past 30'h3FFF_FFFF SHALL continue at 0 without error.
REQ-033 The offset and remaining counters SHALL be 25 bits wide.
REQ-034 The buffer SHALL be CHUNK x 32 bits, with a synchronous write and a combinational or registered read, such that write data is valid in the same cycle stb is asserted.

Reset
REQ-035 On rst=1 at an edge, the state SHALL go to IDLE, and busy, done, cyc, stb, we and csum SHALL be 0, cti 3'b000, and addr and data_o 0.
REQ-036 Reset during a burst SHALL deassert cyc and stb on that same edge, with no further beats issued and a partial copy not resumed.
REQ-037 rst SHALL override a simultaneous start.

Configuration
REQ-038 With macro FLASH_BOOT_CSUM_EN defined, csum SHALL accumulate csum + wbm_data_i (mod 2^32) on each read ack, and be stable and valid while done=1.
REQ-039 Without FLASH_BOOT_CSUM_EN, csum SHALL be constant 0 and no accumulator logic SHALL be present.

Verification
REQ-040 Scenario: WORDS=3, CHUNK=16, zero-wait slave, SRC_BASE=0x100, DST_BASE=0x200.
   -> reads at addresses 0x100..0x102 with cti 010, 010, 111, then one gap cycle;
   -> writes at 0x200..0x202 with the same data;
   -> done=1 one cycle after the final gap.
REQ-041 Scenario: WORDS=20, CHUNK=16.
   -> two read/write pairs of 16 and 4 beats;
   -> second read starts at SRC_BASE+16; last write address is DST_BASE+19.
REQ-042 Scenario: slave inserts 2 wait cycles per beat.
   -> addr, cti and data_o are held for 3 cycles each;
   -> RAM contents match flash contents exactly.
REQ-043 Scenario: rst asserted on beat 5 of a 16-beat read.
   -> cyc=0 and busy=0 on the next cycle; done stays 0; a subsequent start copies from SRC_BASE again.
REQ-044 Scenario: FLASH_BOOT_CSUM_EN defined, flash words 0xFFFFFFFF and 0x00000002.
   -> csum = 0x00000001 at done.
REQ-045 Scenario: WORDS=0 start, or start pulsed while busy.
   -> no bus activity, with done after one busy cycle;
   -> a mid-copy start causes no change to the transfer sequence.
